// File: rtl/fifo_pkg.sv
// Shared helpers for the FIFO read-side blocks: counter widths and lane offsets.
package fifo_pkg;

    // Width of a counter that must hold every value from 0 to n inclusive.
    function automatic int fifo_count_width(input int n);
        return $clog2(n + 1);
    endfunction

    // Bit offset of a lane inside a packed word of equal-width lanes.
    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/incrementer.sv
// Saturating +1 helper; value_next stops at MAX_VALUE and at_max flags it.
module incrementer
    import fifo_pkg::*;
#(
    parameter int MAX_VALUE = 4,
    parameter int WIDTH     = fifo_count_width(MAX_VALUE)
) (
    input  logic [WIDTH-1:0] value,
    output logic [WIDTH-1:0] value_next,
    output logic             at_max
);

    localparam logic [WIDTH-1:0] MAX_L = WIDTH'(MAX_VALUE);

    // Next count, held at the ceiling once it is reached.
    always_comb begin
        at_max     = (value == MAX_L);
        value_next = at_max ? value : value + WIDTH'(1);
    end

endmodule

// File: rtl/stream_output_register.sv
// One-entry valid/ready output register. The owner only loads when free is high.
module stream_output_register #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             free
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign free      = !valid_q || out_ready;

    // Load wins over acceptance; data holds while the word waits.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    // Output state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/fifo_read_packer.sv
// Drains a show-ahead FIFO and packs PACK_COUNT entries (first entry in lane 0)
// into one output word; a flush closes out a partial word.
module fifo_read_packer
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PACK_COUNT = 4
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  fifo_empty,
    input  logic [DATA_WIDTH-1:0]                 fifo_read_data,
    output logic                                  fifo_read_enable,
    input  logic                                  flush,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [DATA_WIDTH*PACK_COUNT-1:0]      out_data,
    output logic [fifo_count_width(PACK_COUNT)-1:0] out_count
);

    localparam int CW = fifo_count_width(PACK_COUNT);
    localparam int LW = $clog2(PACK_COUNT);
    localparam int WW = DATA_WIDTH * PACK_COUNT;

    logic [CW-1:0] fill_q, fill_d, fill_inc;
    logic          fill_full;
    logic          flush_pending_q, flush_pending_d;
    logic [PACK_COUNT-1:0][DATA_WIDTH-1:0] acc_q, acc_d;
    logic [LW-1:0] lane_sel;
    logic          out_free, transfer, pop;
    logic [WW-1:0] word;
    logic [CW+WW-1:0] payload, payload_out;

    incrementer #(
        .MAX_VALUE (PACK_COUNT),
        .WIDTH     (CW)
    ) u_fill_inc (
        .value      (fill_q),
        .value_next (fill_inc),
        .at_max     (fill_full)
    );

    stream_output_register #(
        .WIDTH (CW + WW)
    ) u_out_reg (
        .clk       (clk),
        .reset     (reset),
        .load      (transfer),
        .load_data (payload),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (payload_out),
        .free      (out_free)
    );

    assign out_data         = payload_out[WW-1:0];
    assign out_count        = payload_out[WW +: CW];
    assign fifo_read_enable = pop;

    // Transfer/pop decisions and the next fill and flush state.
    always_comb begin
        transfer = out_free && (fill_full || (flush_pending_q && (fill_q != '0)));
        pop      = !reset && !fifo_empty && !flush_pending_q && (!fill_full || transfer);

        fill_d = fill_q;
        if (transfer && pop) begin
            fill_d = CW'(1);
        end else if (transfer) begin
            fill_d = '0;
        end else if (pop) begin
            fill_d = fill_inc;
        end

        // A pending flush ends on its transfer, or at once when nothing is held.
        flush_pending_d = flush_pending_q;
        if (flush_pending_q) begin
            if (transfer || (fill_q == '0)) begin
                flush_pending_d = 1'b0;
            end
        end else begin
            flush_pending_d = flush;
        end
    end

    // Accumulator write: a pop that coincides with a transfer starts the next word.
    always_comb begin
        acc_d    = acc_q;
        lane_sel = transfer ? '0 : LW'(fill_q);
        if (pop) begin
            acc_d[lane_sel] = fifo_read_data;
        end
    end

    // Outgoing word with lanes at or above fill forced to zero, so stale
    // accumulator contents never leak into a partial word.
    always_comb begin
        word = '0;
        for (int i = 0; i < PACK_COUNT; i++) begin
            if (CW'(i) < fill_q) begin
                word[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH] = acc_q[i];
            end
        end
        payload = {fill_q, word};
    end

    // Control state; reset discards the partial word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fill_q          <= '0;
            flush_pending_q <= 1'b0;
        end else begin
            fill_q          <= fill_d;
            flush_pending_q <= flush_pending_d;
        end
    end

    // Accumulator lanes; validity is tracked by fill alone.
    always_ff @(posedge clk) begin
        acc_q <= acc_d;
    end

endmodule

// File: doc/fifo_read_packer.md
# fifo_read_packer

Read-side consumer for the analyser's clock-crossing FIFO. It drains entries from the FIFO read port in the read clock domain and packs `PACK_COUNT` consecutive entries, first entry in the least significant lane, into one wide word. It presents each word on a registered valid/ready stream to the host-link framer. A flush request emits a partial word so that a capture can be closed out.

## Interface
- `DATA_WIDTH`, 8: width of one FIFO entry.
- `PACK_COUNT`, 4: entries per output word; must be at least 2.
- `clk`  in  1  read-domain clock, the same clock as the FIFO read side.
- `reset`  in  1  asynchronous, active-high reset.
- `fifo_empty`  in  1  FIFO empty flag, synchronous to `clk`.
- `fifo_read_data`  in  DATA_WIDTH  show-ahead head entry; valid whenever `fifo_empty`=0.
- `fifo_read_enable`  out  1  pops the head entry at the rising edge.
- `flush`  in  1  single-cycle request to emit the pending partial word.
- `out_valid`  out  1  output word valid.
- `out_ready`  in  1  downstream accepts the output word.
- `out_data`  out  DATA_WIDTH*PACK_COUNT  packed word; lane i is bits [i*DATA_WIDTH +: DATA_WIDTH].
- `out_count`  out  $clog2(PACK_COUNT+1)  number of valid lanes, from 1 to PACK_COUNT.

## Operation
- Internal state:
  - accumulator with `fill` = 0..PACK_COUNT;
  - `flush_pending` flag;
  - one-entry output register.
- `out_free` = !out_valid | out_ready.
- `transfer` = out_free & ((fill==PACK_COUNT) | (flush_pending & fill!=0)).
- A transfer loads `out_data` and `out_count`=fill, and sets `out_valid`. Lanes at index fill and above are zero.
- `fifo_read_enable` = !reset & !fifo_empty & !flush_pending & ((fill<PACK_COUNT) | transfer).
- On a pop:
  - the entry is written to lane `fill`;
  - if a transfer happens in the same cycle, the entry goes to lane 0 and fill becomes 1;
  - otherwise fill increments by 1.
- Transfer without a pop sets fill to 0.
- States are derived from fill and flush_pending:
  - FILL: fill<PACK_COUNT, no flush pending.
  - STALL: fill==PACK_COUNT and !out_free. No pops in this state.
  - FLUSH: flush_pending=1. Pops are inhibited. The state exits on a transfer, or immediately (next edge) if fill==0, with no word emitted. flush_pending then clears.
- `flush` is sampled every cycle:
  - A pop in the same cycle as `flush` is included in the flushed word.
  - `flush` while already pending has no further effect.
  - If fill reaches PACK_COUNT while a flush is pending, the full word satisfies the flush and out_count=PACK_COUNT.
- The output register holds `out_data` and `out_count` stable while out_valid & !out_ready. It clears `out_valid` on acceptance unless it is reloaded in the same cycle.
- `fifo_empty` going high mid-word stalls filling; no output is produced until the word completes or a flush arrives.

## Timing
- Reset values:
  - out_valid=0, out_data=0, out_count=0;
  - fill=0, flush_pending=0;
  - fifo_read_enable=0 while reset is high.
- Reset mid-word discards the accumulator and the output register. No entry is popped during reset.
- Latency: the final pop of a word at edge N gives out_valid=1 after edge N+1.
- Throughput: one pop per cycle sustained when out_ready=1. The word boundary causes no bubble.
- Flush latency: after `flush` at edge N, the partial word is valid after edge N+1 if the output register is free; otherwise it follows the acceptance of the occupying word.
- Back-pressure: with out_ready=0, at most PACK_COUNT entries plus one output word are absorbed, then pops stop.

## Structure
- Shared package `fifo_pkg` holds:
  - `fifo_count_width(PACK_COUNT)`, equal to $clog2(PACK_COUNT+1);
  - the lane-index helper used by this block and the FIFO counters.
- Sub-module `stream_output_register`: one-entry valid/ready register with load and accept. The host-link framer reuses it.
- Fill counting reuses the existing `incrementer` with MAX_VALUE=PACK_COUNT.

## Test plan
- FIFO preloaded with 0x11,0x22,0x33,0x44,0x55,0x66,0x77,0x88 and out_ready=1 → two words, 0x44332211 then 0x88776655, each with out_count=4. fifo_read_enable is high for 8 consecutive cycles.
- Three entries 0xA1,0xB2,0xC3, then `flush` → one word 0x00C3B2A1 with out_count=3, valid 2 edges after flush. flush_pending then clears.
- `flush` with fill=0 → no out_valid. Pops resume on the next cycle.
- out_ready=0 with 12 entries queued → pops stop after 8. out_data holds 0x44332211 stable. Raising out_ready drains the remaining words in order.
- `flush` in the same cycle as the 4th pop → full word, out_count=4, and no extra empty word.
- reset asserted mid-word with fill=2 → out_valid=0 and fill=0 immediately. The next 4 pops form a fresh word with lane 0 equal to the first post-reset entry.
